// File: rtl/demux_seq_pkg.sv
// Shared constants and FSM state type for the demux sequence driver.
// Used by demux_seq_driver and demux_seq_next_ch.
package demux_seq_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_BIT,
    ST_DWELL,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/demux_seq_next_ch.sv
// Combinational search for the lowest set mask bit strictly above idx_i.
// found_o is low when no such bit exists.
module demux_seq_next_ch
  import demux_seq_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [SEL_W-1:0]  idx_i,
  output logic [SEL_W-1:0]  next_o,
  output logic              found_o
);

  logic [NUM_CH-1:0] above;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_above
      assign above[gi] = mask_i[gi] && (SEL_W'(gi) > idx_i);
    end
  endgenerate

  // Descending scan so the last hit, i.e. the lowest candidate, wins.
  always_comb begin
    next_o  = '0;
    found_o = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (above[i]) begin
        next_o  = SEL_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_seq_driver.sv
// Sequences single din bits across the enabled channels of a downstream 1x8 demux.
// Optional macro DEMUX_SEQ_CONTINUOUS_EN: wrap sweeps until a start pulse requests stop.
module demux_seq_driver
  import demux_seq_pkg::*;
#(
  parameter int DWELL  = 4,
  parameter int NUM_CH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_CH-1:0] mask,
  input  logic              din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              in,
  output logic [SEL_W-1:0]  sel,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [7:0] CNT_INIT = 8'(DWELL - 1);

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              in_q, in_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [NUM_CH-1:0] low_mask;
  logic [SEL_W-1:0]  low_above, low_ch, nxt_ch;
  logic              low_found, nxt_found, has_ch, stop_req;

  // One search finds the first channel (bit 0 checked directly), the other steps upward.
  assign low_mask = (state_q == ST_IDLE) ? mask : mask_q;
  assign low_ch   = low_mask[0] ? '0 : low_above;
  assign has_ch   = low_mask[0] | low_found;

  demux_seq_next_ch u_low (
    .mask_i  (low_mask),
    .idx_i   ('0),
    .next_o  (low_above),
    .found_o (low_found)
  );

  demux_seq_next_ch u_next (
    .mask_i  (mask_q),
    .idx_i   (sel_q),
    .next_o  (nxt_ch),
    .found_o (nxt_found)
  );

`ifdef DEMUX_SEQ_CONTINUOUS_EN
  logic stop_q, stop_d;
  assign stop_req = stop_q | start;
`else
  assign stop_req = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    sel_d       = sel_q;
    in_d        = in_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
`ifdef DEMUX_SEQ_CONTINUOUS_EN
    stop_d      = stop_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (has_ch) begin
            mask_d  = mask;
            sel_d   = low_ch;
            busy_d  = 1'b1;
            state_d = ST_WAIT_BIT;
          end else begin
            done_d  = 1'b1;
            state_d = ST_FINISH;
          end
        end
      end
      ST_WAIT_BIT: begin
        if (din_valid) begin
          in_d        = din;
          out_valid_d = 1'b1;
          cnt_d       = CNT_INIT;
          state_d     = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          out_valid_d = 1'b0;
          in_d        = 1'b0;
          if (stop_req) begin
            done_d  = 1'b1;
            state_d = ST_FINISH;
          end else if (nxt_found) begin
            sel_d   = nxt_ch;
            state_d = ST_WAIT_BIT;
          end else begin
`ifdef DEMUX_SEQ_CONTINUOUS_EN
            sel_d   = low_ch;
            done_d  = 1'b1;
            state_d = ST_WAIT_BIT;
`else
            done_d  = 1'b1;
            state_d = ST_FINISH;
`endif
          end
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
`ifdef DEMUX_SEQ_CONTINUOUS_EN
        stop_d  = 1'b0;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef DEMUX_SEQ_CONTINUOUS_EN
    if (start && (state_q == ST_WAIT_BIT || state_q == ST_DWELL)) begin
      stop_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      sel_q       <= '0;
      in_q        <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= 8'd0;
`ifdef DEMUX_SEQ_CONTINUOUS_EN
      stop_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      sel_q       <= sel_d;
      in_q        <= in_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
`ifdef DEMUX_SEQ_CONTINUOUS_EN
      stop_q      <= stop_d;
`endif
    end
  end

  assign din_ready = (state_q == ST_WAIT_BIT);
  assign in        = in_q;
  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_demux_seq_driver.sv
// Scoreboard bench for demux_seq_driver (default single-sweep build).
// Driver pushes expected windows/done pulses; a negedge monitor pops and compares.
module tb_demux_seq_driver;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] mask = 8'h00;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       din_ready, in_o, out_valid, busy, done;
  logic [2:0] sel;

  demux_seq_driver #(.DWELL(D), .NUM_CH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mask      (mask),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .in        (in_o),
    .sel       (sel),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int b;
    int cyc;
  } win_t;

  win_t exp_q[$];
  int   done_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: each out_valid window must match the next expected (channel, bit, start cycle).
  logic prev_ov = 1'b0;
  int   win_len = 0;
  int   win_sel = 0;
  int   win_in = 0;
  win_t mw;

  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
      win_len = 0;
    end else begin
      if (out_valid) begin
        if (!prev_ov) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_window", 1, 0);
          end else begin
            mw = exp_q.pop_front();
            chk("win_sel", int'(sel), mw.ch);
            chk("win_in", int'(in_o), mw.b);
            chk("win_start_cycle", cyc, mw.cyc);
          end
          win_len = 1;
          win_sel = int'(sel);
          win_in  = int'(in_o);
        end else begin
          chk("sel_stable", int'(sel), win_sel);
          chk("in_stable", int'(in_o), win_in);
          win_len++;
        end
        chk("busy_in_window", int'(busy), 1);
        chk("ready_in_window", int'(din_ready), 0);
      end else begin
        chk("in_idle_zero", int'(in_o), 0);
        if (prev_ov) chk("win_len", win_len, D);
      end
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_cycle", cyc, done_q.pop_front());
      end
      prev_ov = out_valid;
    end
  end

  // One sweep from a negedge. gap_fix/bit_fix < 0 means random; abort_at >= 0
  // asserts reset mid-dwell on that channel index of the sweep.
  task automatic run_sweep(input logic [7:0] m, input int gap_fix, input int bit_fix,
                           input int abort_at);
    int chs[$];
    int n, gap, b;
    for (int i = 0; i < 8; i++) if (m[i]) chs.push_back(i);
    din_valid = 1'b0;
    start = 1'b1;
    mask = m;
    if (chs.size() == 0) done_q.push_back(cyc + 1);
    @(negedge clk);
    start = 1'b0;
    mask = 8'($urandom);
    if (chs.size() == 0) begin
      chk("empty_busy", int'(busy), 0);
      chk("empty_ready", int'(din_ready), 0);
      chk("empty_ov", int'(out_valid), 0);
      @(negedge clk);
      chk("empty_ready2", int'(din_ready), 0);
      chk("empty_done_once", int'(done), 0);
      return;
    end
    chk("busy_after_start", int'(busy), 1);
    foreach (chs[j]) begin
      n = 0;
      while (!din_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!din_ready) begin
        chk("ready_timeout", 0, 1);
        return;
      end
      gap = (gap_fix < 0) ? int'($urandom_range(0, 3)) : gap_fix;
      b   = (bit_fix < 0) ? int'($urandom_range(0, 1)) : bit_fix;
      din_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        chk("wait_sel", int'(sel), chs[j]);
        chk("wait_ov", int'(out_valid), 0);
        chk("wait_ready", int'(din_ready), 1);
        chk("wait_busy", int'(busy), 1);
        @(negedge clk);
      end
      chk("hs_ready", int'(din_ready), 1);
      din = b[0];
      din_valid = 1'b1;
      exp_q.push_back('{chs[j], b, cyc + 1});
      if (j == chs.size() - 1) done_q.push_back(cyc + 1 + D);
      @(negedge clk);
      din_valid = 1'($urandom_range(0, 1));
      din = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        start = 1'b1;
        mask = 8'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      if (j == abort_at) begin
        chk("pre_reset_sel", int'(sel), chs[j]);
        chk("pre_reset_ov", int'(out_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_in", int'(in_o), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_ov", int'(out_valid), 0);
        chk("rst_ready", int'(din_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        exp_q.delete();
        done_q.delete();
        din_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
    n = 0;
    while (done_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done_q.size(), 0);
    @(negedge clk);
    chk("busy_end", int'(busy), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_in", int'(in_o), 0);
    chk("reset_sel", int'(sel), 0);
    chk("reset_ov", int'(out_valid), 0);
    chk("reset_ready", int'(din_ready), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    rst = 1'b0;
    run_sweep(8'hFF, 0, 1, -1);
    run_sweep(8'b1000_0101, -1, -1, -1);
    run_sweep(8'h00, -1, -1, -1);
    run_sweep(8'h24, 3, 0, -1);
    run_sweep(8'h1A, -1, -1, 1);
    run_sweep(8'h1A, -1, -1, -1);
    run_sweep(8'h80, -1, -1, -1);
    run_sweep(8'h01, -1, -1, -1);
    for (int t = 0; t < 20; t++) run_sweep(8'($urandom), -1, -1, -1);
    repeat (3) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
